i2s_tx_sequencer: RTL and testbench



---
 rtl/i2s_pkg.sv | 28 ++
 rtl/i2s_tx_sequencer_clk_gen.sv | 49 ++++
 rtl/i2s_tx_sequencer.sv | 109 ++++++++++
 tb/tb_i2s_tx_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S transmit sequencer.
package i2s_pkg;

    localparam int SLOT_W           = 32;
    localparam int SAMPLE_W_DEFAULT = 16;

    typedef logic signed [SAMPLE_W_DEFAULT-1:0] sample_t;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } seq_state_t;

    // Add two samples one bit wider than the inputs, then clamp to the sample range.
    function automatic sample_t sat_add(input sample_t a, input sample_t b);
        logic signed [SAMPLE_W_DEFAULT:0] sum;
        sample_t                          res;
        sum = {a[SAMPLE_W_DEFAULT-1], a} + {b[SAMPLE_W_DEFAULT-1], b};
        if (sum[SAMPLE_W_DEFAULT] != sum[SAMPLE_W_DEFAULT-1]) begin
            res = sum[SAMPLE_W_DEFAULT] ? {1'b1, {(SAMPLE_W_DEFAULT-1){1'b0}}}
                                        : {1'b0, {(SAMPLE_W_DEFAULT-1){1'b1}}};
        end else begin
            res = sum[SAMPLE_W_DEFAULT-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/i2s_tx_sequencer_clk_gen.sv
// Bit clock and word-select generator: SCLK from a CLK divider, LRCLK every BITS_PER_CH SCLK periods.
module i2s_clk_gen #(
    parameter int SCLK_DIV    = 4,
    parameter int BITS_PER_CH = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    output logic                           sclk,
    output logic                           lrclk,
    output logic [$clog2(BITS_PER_CH)-1:0] bit_cnt,
    output logic                           sclk_fall,
    output logic                           half_frame_start
);

    localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int BW = $clog2(BITS_PER_CH);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(BITS_PER_CH - 1);

    logic [DW-1:0] div_cnt;
    logic          div_tc;

    assign div_tc           = (div_cnt == DIV_LAST);
    // Strobes describe what happens at the coming edge, so the sequencer can act in the same edge.
    assign sclk_fall        = div_tc & sclk;
    assign half_frame_start = sclk_fall & (bit_cnt == BIT_LAST);

    // Divider, SCLK toggle, bit counter on SCLK fall and LRCLK toggle on bit counter wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
            lrclk   <= 1'b0;
            bit_cnt <= '0;
        end else begin
            div_cnt <= div_tc ? '0 : div_cnt + DW'(1);
            if (div_tc) begin
                sclk <= ~sclk;
            end
            if (sclk_fall) begin
                bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);
            end
            if (half_frame_start) begin
                lrclk <= ~lrclk;
            end
        end
    end

endmodule

// File: rtl/i2s_tx_sequencer.sv
// I2S transmit sequencer: per half-frame fetches a music and optional SFX sample, mixes with
// saturation, left-justifies into the 32-bit slot and substitutes silence on a missed deadline.
module i2s_tx_sequencer
    import i2s_pkg::*;
#(
    parameter int SCLK_DIV    = 4,
    parameter int BITS_PER_CH = 32,
    parameter int SAMPLE_W    = SAMPLE_W_DEFAULT
) (
    input  logic                       CLK,
    input  logic                       Reset,
    input  logic                       enable,
    input  logic signed [SAMPLE_W-1:0] music_data,
    input  logic                       music_valid,
    output logic                       music_ready,
    input  logic signed [SAMPLE_W-1:0] sfx_data,
    input  logic                       sfx_valid,
    output logic                       sfx_ready,
    output logic                       req_chan,
    output logic                       SCLK,
    output logic                       LRCLK,
    output logic [SLOT_W-1:0]          DIN,
    output logic [15:0]                underrun_count
);

    localparam int BW = $clog2(BITS_PER_CH);
    // Fetching is allowed only while bit_cnt < BITS_PER_CH-2; the deadline edge is the SCLK fall
    // that moves bit_cnt onto BITS_PER_CH-2.
    localparam logic [BW-1:0] FETCH_LIMIT = BW'(BITS_PER_CH - 2);
    localparam logic [BW-1:0] DL_BIT      = BW'(BITS_PER_CH - 3);

    logic [BW-1:0] bit_cnt;
    logic          sclk_fall;
    logic          half_frame_start;

    seq_state_t    state, state_nxt;
    logic          ready_q, ready_nxt;
    logic [SLOT_W-1:0] din_nxt;
    logic [15:0]   count_nxt;
    logic          transfer;
    logic          deadline;
    sample_t       mix;

    i2s_clk_gen #(
        .SCLK_DIV    (SCLK_DIV),
        .BITS_PER_CH (BITS_PER_CH)
    ) u_clk_gen (
        .clk              (CLK),
        .rst              (Reset),
        .sclk             (SCLK),
        .lrclk            (LRCLK),
        .bit_cnt          (bit_cnt),
        .sclk_fall        (sclk_fall),
        .half_frame_start (half_frame_start)
    );

    // Right word is loaded while LRCLK=0, left word while LRCLK=1.
    assign req_chan    = ~LRCLK;
    // Ready is registered; mute and reset gate it so no handshake can complete in those cycles.
    assign music_ready = ready_q & enable & ~Reset;
    assign sfx_ready   = music_ready & music_valid & sfx_valid;
    assign transfer    = music_ready & music_valid;
    assign deadline    = sclk_fall & (bit_cnt == DL_BIT);
    assign mix         = sat_add(sample_t'(music_data), sfx_valid ? sample_t'(sfx_data) : sample_t'(0));

    // Next-state, ready, slot word and underrun counter decisions.
    always_comb begin
        state_nxt = state;
        ready_nxt = 1'b0;
        din_nxt   = DIN;
        count_nxt = underrun_count;
        if (!enable) begin
            state_nxt = HOLD;
            din_nxt   = '0;
        end else if (state == FETCH) begin
            if (transfer) begin
                din_nxt   = {mix, {(SLOT_W-SAMPLE_W_DEFAULT){1'b0}}};
                state_nxt = HOLD;
            end else if (deadline) begin
                din_nxt   = '0;
                count_nxt = (underrun_count == 16'hFFFF) ? underrun_count : underrun_count + 16'd1;
                state_nxt = HOLD;
            end else begin
                ready_nxt = (bit_cnt < FETCH_LIMIT);
            end
        end
        // Every LRCLK toggle opens a new fetch window for the other channel.
        if (half_frame_start) begin
            state_nxt = FETCH;
            ready_nxt = 1'b0;
        end
    end

    // Sequencer state, ready flag, slot word and underrun counter registers.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state          <= FETCH;
            ready_q        <= 1'b0;
            DIN            <= '0;
            underrun_count <= '0;
        end else begin
            state          <= state_nxt;
            ready_q        <= ready_nxt;
            DIN            <= din_nxt;
            underrun_count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// Self-checking bench for i2s_tx_sequencer: one half-frame at a time against a frame-level model.
module tb_i2s_tx_sequencer;

    localparam int SCLK_DIV    = 4;
    localparam int BITS_PER_CH = 32;
    localparam int HF          = 2 * SCLK_DIV * BITS_PER_CH;            // CLK cycles per half-frame
    localparam int DL_LAST     = (BITS_PER_CH - 2) * 2 * SCLK_DIV - 1;  // last cycle a transfer may occur
    localparam int EN_ON       = 0;
    localparam int EN_OFF      = 1;
    localparam int EN_LATE     = 2;
    localparam int EN_LATE_AT  = 100;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        enable;
    logic [15:0] music_data;
    logic        music_valid;
    logic        music_ready;
    logic [15:0] sfx_data;
    logic        sfx_valid;
    logic        sfx_ready;
    logic        req_chan;
    logic        SCLK;
    logic        LRCLK;
    logic [31:0] DIN;
    logic [15:0] underrun_count;

    int n_tests = 0;
    int n_fail  = 0;
    int hf_idx  = 0;
    int exp_und = 0;

    i2s_tx_sequencer #(
        .SCLK_DIV    (SCLK_DIV),
        .BITS_PER_CH (BITS_PER_CH),
        .SAMPLE_W    (16)
    ) dut (
        .CLK            (CLK),
        .Reset          (Reset),
        .enable         (enable),
        .music_data     (music_data),
        .music_valid    (music_valid),
        .music_ready    (music_ready),
        .sfx_data       (sfx_data),
        .sfx_valid      (sfx_valid),
        .sfx_ready      (sfx_ready),
        .req_chan       (req_chan),
        .SCLK           (SCLK),
        .LRCLK          (LRCLK),
        .DIN            (DIN),
        .underrun_count (underrun_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected slot word: clamp the true sum to the 16-bit signed range, place it in the top half.
    function automatic logic [31:0] model_din(input logic [15:0] m, input logic [15:0] s, input bit sv);
        int sum;
        logic [15:0] r;
        sum = int'($signed(m)) + (sv ? int'($signed(s)) : 0);
        if (sum > 32767)  sum = 32767;
        if (sum < -32768) sum = -32768;
        r = 16'(sum);
        return {r, 16'h0000};
    endfunction

    task automatic chk_reset_values(input string tag);
        chk({tag, "_sclk"},     SCLK,           0);
        chk({tag, "_lrclk"},    LRCLK,          0);
        chk({tag, "_din"},      DIN,            0);
        chk({tag, "_mready"},   music_ready,    0);
        chk({tag, "_sready"},   sfx_ready,      0);
        chk({tag, "_req_chan"}, req_chan,       1);
        chk({tag, "_underrun"}, underrun_count, 0);
    endtask

    // Runs one full half-frame starting at the negedge of its first cycle; the source offers
    // (m, s) from offset v_off and withdraws after acceptance or at the end of the half-frame.
    task automatic run_hf(input logic [15:0] m, input logic [15:0] s, input bit sv,
                          input int v_off, input int mode);
        bit          accepted   = 0;
        bit          ready_dl   = 0;
        bit          lr         = hf_idx[0];
        bit          on         = (mode == EN_ON);
        bit          offered    = (v_off <= DL_LAST);
        bit          exp_x;
        int          xfers      = 0;
        int          sfx_xfers  = 0;
        int          ready_bad  = 0;
        int          clk_bad    = 0;
        logic [31:0] din_late   = '0;
        exp_x = on && offered;
        if (on && !offered && exp_und < 65535) exp_und++;
        for (int o = 0; o < HF; o++) begin
            enable      = (mode == EN_ON) || (mode == EN_LATE && o >= EN_LATE_AT);
            music_data  = m;
            sfx_data    = s;
            music_valid = (o >= v_off) && !accepted;
            sfx_valid   = sv && !accepted;
            #1;
            if (SCLK !== (((o / SCLK_DIV) % 2) != 0)) clk_bad++;
            if (LRCLK !== lr)                           clk_bad++;
            if (req_chan !== !lr)                       clk_bad++;
            if (music_ready && (o > DL_LAST || !enable || accepted)) ready_bad++;
            if (sfx_ready !== (music_ready & music_valid & sfx_valid)) ready_bad++;
            if (o == DL_LAST && !accepted) ready_dl = music_ready;
            if (music_valid && music_ready) begin
                xfers++;
                accepted = 1;
                if (sfx_valid && sfx_ready) sfx_xfers++;
            end
            if (o == HF - 6) din_late = DIN;
            @(negedge CLK);
        end
        music_valid = 1'b0;
        sfx_valid   = 1'b0;
        chk("transfers",   xfers,     exp_x ? 1 : 0);
        chk("sfx_taken",   sfx_xfers, (exp_x && sv) ? 1 : 0);
        chk("din",         din_late,  exp_x ? model_din(m, s, sv) : 32'h0);
        chk("underrun",    underrun_count, exp_und);
        chk("ready_rules", ready_bad, 0);
        chk("clocks",      clk_bad,   0);
        if (on && !offered) chk("ready_at_deadline", ready_dl, 1);
        hf_idx++;
    endtask

    initial begin
        Reset       = 1'b1;
        enable      = 1'b1;
        music_data  = '0;
        music_valid = 1'b0;
        sfx_data    = '0;
        sfx_valid   = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        chk_reset_values("reset");
        Reset = 1'b0;

        // Steady music, no SFX: one transfer per half-frame, req_chan 1,0,1.
        for (int i = 0; i < 3; i++) run_hf(16'h1234, 16'h0000, 0, 0, EN_ON);

        // Saturation at both rails.
        run_hf(16'h7000, 16'h2000, 1, int'($urandom_range(0, 200)), EN_ON);
        run_hf(16'h9000, 16'hE000, 1, int'($urandom_range(0, 200)), EN_ON);

        // Missed deadline, then recovery.
        run_hf(16'h1111, 16'h2222, 1, HF, EN_ON);
        run_hf(16'($urandom), 16'($urandom), 1, int'($urandom_range(0, 100)), EN_ON);

        // Late offers: last SCLK-low cycle of bit 29, the deadline cycle itself, one cycle too late.
        run_hf(16'($urandom), 16'($urandom), 0, DL_LAST - SCLK_DIV, EN_ON);
        run_hf(16'($urandom), 16'($urandom), 1, DL_LAST, EN_ON);
        run_hf(16'($urandom), 16'($urandom), 1, DL_LAST + 1, EN_ON);

        // Muted for three half-frames, then re-enabled mid-half-frame.
        for (int i = 0; i < 3; i++) run_hf(16'($urandom), 16'($urandom), 1, 0, EN_OFF);
        run_hf(16'($urandom), 16'($urandom), 1, 0, EN_LATE);

        // Randomized traffic.
        for (int i = 0; i < 4; i++)
            run_hf(16'($urandom), 16'($urandom), bit'($urandom_range(0, 1)),
                   int'($urandom_range(0, DL_LAST)), EN_ON);

        // Reset while the fetch window is open.
        enable      = 1'b1;
        music_valid = 1'b0;
        sfx_valid   = 1'b0;
        repeat (40) @(negedge CLK);
        #1;
        chk("ready_before_reset", music_ready, 1);
        Reset       = 1'b1;
        music_valid = 1'b1;
        sfx_valid   = 1'b1;
        #1;
        chk("mready_in_reset", music_ready, 0);
        chk("sready_in_reset", sfx_ready, 0);
        @(negedge CLK);
        #1;
        chk_reset_values("mid_reset");
        Reset       = 1'b0;
        music_valid = 1'b0;
        sfx_valid   = 1'b0;
        hf_idx      = 0;
        exp_und     = 0;
        run_hf(16'hABCD, 16'h0123, 1, 0, EN_ON);
        run_hf(16'($urandom), 16'($urandom), 0, int'($urandom_range(0, DL_LAST)), EN_ON);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
